// File: rtl/ddram_arb.sv
// ddram_arb: shares one ddram write/read toggle port among
// NCH single-word requesters, round-robin or fixed priority.
module ddram_arb #(
  parameter int NCH = 3,
  parameter bit RR  = 1'b1
) (
  input  logic              DDRAM_CLK,
  input  logic              RESET_N,
  input  logic [NCH*27-1:0] ch_addr,
  input  logic [NCH*16-1:0] ch_din,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH-1:0]    ch_req,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH*16-1:0] ch_dout,
  output logic [27:0]       wraddr,
  output logic [15:0]       din,
  output logic              we_req,
  input  logic              we_ack,
  output logic [26:0]       rdaddr,
  output logic              rd_req,
  input  logic              rd_ack,
  input  logic [15:0]       dout
);

  localparam int GW = $clog2(NCH);

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    WAIT
  } state_e;

  state_e state_q, state_d;

  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic          op_q, op_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0][15:0] dout_q, dout_d;
  logic [27:0]   wraddr_q, wraddr_d;
  logic [15:0]   din_q, din_d;
  logic          we_req_q, we_req_d;
  logic [26:0]   rdaddr_q, rdaddr_d;
  logic          rd_req_q, rd_req_d;

  logic [NCH-1:0][26:0] addr_a;
  logic [NCH-1:0][15:0] din_a;
  logic [NCH-1:0] pend;
  logic [GW-1:0]  base;
  logic [GW-1:0]  sel;
  logic           sel_vld;
  logic [GW:0]    idx;
  logic           done;

  assign addr_a = ch_addr;
  assign din_a  = ch_din;
  assign pend   = ch_req ^ ack_q;
  assign base   = RR ? rr_ptr_q : '0;

  // Pick the first pending channel scanning upward from base, wrapping at NCH.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = {1'b0, base} + (GW+1)'(k);
      if (idx >= (GW+1)'(NCH)) idx = idx - (GW+1)'(NCH);
      if (!sel_vld && pend[idx[GW-1:0]]) begin
        sel_vld = 1'b1;
        sel     = idx[GW-1:0];
      end
    end
  end

  assign done = op_q ? (we_ack == we_req_q) : (rd_ack == rd_req_q);

  // Next-state and datapath updates for the SYNC/IDLE/WAIT sequencer.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    op_d     = op_q;
    ack_d    = ack_q;
    dout_d   = dout_q;
    wraddr_d = wraddr_q;
    din_d    = din_q;
    we_req_d = we_req_q;
    rdaddr_d = rdaddr_q;
    rd_req_d = rd_req_q;
    unique case (state_q)
      SYNC: begin
        we_req_d = we_ack;
        rd_req_d = rd_ack;
        state_d  = IDLE;
      end
      IDLE: begin
        if (sel_vld) begin
          grant_d = sel;
          op_d    = ch_we[sel];
          if (ch_we[sel]) begin
            wraddr_d = {addr_a[sel], 1'b0};
            din_d    = din_a[sel];
            we_req_d = ~we_req_q;
          end else begin
            rdaddr_d = addr_a[sel];
            rd_req_d = ~rd_req_q;
          end
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (done) begin
          ack_d[grant_q] = ~ack_q[grant_q];
          if (!op_q) dout_d[grant_q] = dout;
          if (RR) begin
            rr_ptr_d = (grant_q == GW'(NCH-1)) ? '0
                                               : grant_q + GW'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // State and output registers; reset abandons any open transaction.
  always_ff @(posedge DDRAM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= SYNC;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      op_q     <= 1'b0;
      ack_q    <= '0;
      dout_q   <= '0;
      wraddr_q <= '0;
      din_q    <= '0;
      we_req_q <= 1'b0;
      rdaddr_q <= '0;
      rd_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      op_q     <= op_d;
      ack_q    <= ack_d;
      dout_q   <= dout_d;
      wraddr_q <= wraddr_d;
      din_q    <= din_d;
      we_req_q <= we_req_d;
      rdaddr_q <= rdaddr_d;
      rd_req_q <= rd_req_d;
    end
  end

  assign ch_ack  = ack_q;
  assign ch_dout = dout_q;
  assign wraddr  = wraddr_q;
  assign din     = din_q;
  assign we_req  = we_req_q;
  assign rdaddr  = rdaddr_q;
  assign rd_req  = rd_req_q;

endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: RR=1 and RR=0 arbiters, each on its own
// toggle-handshake ddram model, checked against a reference.
module tb_ddram_arb;

  localparam int NCH = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [NCH*27-1:0] ch_addr [2];
  logic [NCH*16-1:0] ch_din  [2];
  logic [NCH-1:0]    ch_we   [2];
  logic [NCH-1:0]    ch_req  [2];
  logic [NCH-1:0]    ch_ack  [2];
  logic [NCH*16-1:0] ch_dout [2];
  logic [27:0]       wraddr  [2];
  logic [15:0]       din     [2];
  logic              we_req  [2];
  logic              we_ack  [2];
  logic [26:0]       rdaddr  [2];
  logic              rd_req  [2];
  logic              rd_ack  [2];
  logic [15:0]       dout    [2];
  int                lat     [2];

  always #5 clk = ~clk;

  function automatic logic [15:0] memv(int u, int i);
    if (i == 0) return 16'hA55A;
    return 16'((i * 37 + u * 1000) ^ 16'hC3A5);
  endfunction

  for (genvar u = 0; u < 2; u++) begin : g_u
    logic [15:0] mem [256];
    logic wack = 1'b1;
    logic rack = 1'b0;
    logic wprev = 1'b0;
    logic rprev = 1'b0;
    logic wb = 1'b0;
    logic rb = 1'b0;
    int   wc = 0;
    int   rc = 0;

    assign we_ack[u] = wack;
    assign rd_ack[u] = rack;
    assign dout[u]   = mem[rdaddr[u][7:0]];

    initial for (int i = 0; i < 256; i++) mem[i] = memv(u, i);

    // ddram model: starts on a req toggle, acks after lat cycles.
    always @(posedge clk) begin
      wprev <= we_req[u];
      rprev <= rd_req[u];
      if (!wb) begin
        if (rst_n && we_req[u] !== wprev && we_req[u] !== wack) begin
          wb <= 1'b1;
          wc <= (lat[u] > 0) ? lat[u] : int'($urandom_range(1, 4));
        end
      end else if (wc <= 1) begin
        mem[wraddr[u][8:1]] <= din[u];
        wack <= ~wack;
        wb   <= 1'b0;
      end else wc <= wc - 1;
      if (!rb) begin
        if (rst_n && rd_req[u] !== rprev && rd_req[u] !== rack) begin
          rb <= 1'b1;
          rc <= (lat[u] > 0) ? lat[u] : int'($urandom_range(1, 4));
        end
      end else if (rc <= 1) begin
        rack <= ~rack;
        rb   <= 1'b0;
      end else rc <= rc - 1;
    end

    ddram_arb #(.NCH(NCH), .RR(u == 0)) dut (
      .DDRAM_CLK(clk),
      .RESET_N  (rst_n),
      .ch_addr  (ch_addr[u]),
      .ch_din   (ch_din[u]),
      .ch_we    (ch_we[u]),
      .ch_req   (ch_req[u]),
      .ch_ack   (ch_ack[u]),
      .ch_dout  (ch_dout[u]),
      .wraddr   (wraddr[u]),
      .din      (din[u]),
      .we_req   (we_req[u]),
      .we_ack   (we_ack[u]),
      .rdaddr   (rdaddr[u]),
      .rd_req   (rd_req[u]),
      .rd_ack   (rd_ack[u]),
      .dout     (dout[u])
    );
  end

  int n_ok  = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // reference state
  logic [15:0]       ref_mem [2][256];
  logic [26:0]       q_addr  [2][NCH];
  logic [15:0]       q_din   [2][NCH];
  bit                q_we    [2][NCH];
  logic [NCH-1:0]    pend    [2];
  logic [NCH-1:0]    exp_ack [2];
  logic [NCH*16-1:0] exp_dout[2];
  int ptr[2], cur[2], acknext[2];
  logic pw[2], pr[2], pwa[2], pra[2];

  function automatic logic [26:0] tag_addr(int c, int lo);
    return {17'($urandom), 2'(c), 8'(lo)};
  endfunction

  task automatic issue(input int u, input int c, input bit we,
                       input logic [26:0] a, input logic [15:0] d);
    ch_addr[u][c*27 +: 27] = a;
    ch_din[u][c*16 +: 16]  = d;
    ch_we[u][c]  = we;
    ch_req[u][c] = ~ch_req[u][c];
    q_addr[u][c] = a;
    q_din[u][c]  = d;
    q_we[u][c]   = we;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ch_req[0] = '0;
    ch_req[1] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ack(input int u, input int c, input logic v,
                          input string tag);
    int k = 0;
    while (ch_ack[u][c] !== v && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(tag, ch_ack[u][c], v);
  endtask

  function automatic int exp_grant(int u);
    for (int k = 0; k < NCH; k++) begin
      int c = (u == 0) ? (ptr[u] + k) % NCH : k;
      if (pend[u][c]) return c;
    end
    return -1;
  endfunction

  int seq[2][$];
  int exp_rr[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int exp_fp[6] = '{0, 0, 0, 0, 1, 2};

  initial begin
    int k, n, g, cnt[2][NCH];
    logic prev;
    logic [NCH-1:0] pa[2];
    bit moved[2], wt, rt, wa, ra;

    for (int u = 0; u < 2; u++) begin
      ch_addr[u] = '0;
      ch_din[u]  = '0;
      ch_we[u]   = '0;
      ch_req[u]  = '0;
      lat[u]     = 3;
      for (int i = 0; i < 256; i++) ref_mem[u][i] = memv(u, i);
    end

    // reset state, then SYNC aligns to the model's acks
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_ctl", {ch_ack[u], we_req[u], rd_req[u], din[u]}, '0);
      chk("rst_addr", {wraddr[u], rdaddr[u]}, '0);
      chk("rst_dout", ch_dout[u], '0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("sync_we", we_req[u], 1'b1);
      chk("sync_rd", rd_req[u], 1'b0);
      moved[u] = 1'b0;
    end
    repeat (10) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++)
        if (we_req[u] !== 1'b1 || rd_req[u] !== 1'b0) moved[u] = 1'b1;
    end
    for (int u = 0; u < 2; u++) chk("idle_hold", moved[u], 1'b0);

    // ch1 write, 5-cycle model latency
    lat[0] = 5;
    issue(0, 1, 1'b1, 27'h0001234, 16'hBEEF);
    @(negedge clk);
    chk("wr_addr", wraddr[0], 28'h0002468);
    chk("wr_din", din[0], 16'hBEEF);
    chk("wr_tog", we_req[0], 1'b0);
    k = 0;
    while (we_ack[0] !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("wr_model_ack", k < 50, 1'b1);
    chk("wr_ack_pre", ch_ack[0], 3'b000);
    @(negedge clk);
    chk("wr_ack", ch_ack[0], 3'b010);
    chk("wr_dout", ch_dout[0], '0);
    ref_mem[0][8'h34] = 16'hBEEF;

    // ch0 read of preloaded word
    lat[0] = 3;
    issue(0, 0, 1'b0, 27'h0000100, 16'h0000);
    @(negedge clk);
    chk("rd_addr", rdaddr[0], 27'h0000100);
    chk("rd_tog", rd_req[0], 1'b1);
    k = 0;
    while (rd_ack[0] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rd_pre", {ch_ack[0], ch_dout[0][15:0]}, {3'b010, 16'h0000});
    @(negedge clk);
    chk("rd_data", ch_dout[0][15:0], 16'hA55A);
    chk("rd_ack", ch_ack[0], 3'b011);
    issue(0, 1, 1'b1, 27'h0000155, 16'h1111);
    wait_ack(0, 1, 1'b0, "wr2_ack");
    chk("rd_hold", rdaddr[0], 27'h0000100);
    ref_mem[0][8'h55] = 16'h1111;

    // service order: RR=1 all streaming, RR=0 ch0 hogging
    do_reset();
    lat[0] = 2;
    lat[1] = 2;
    for (int u = 0; u < 2; u++) begin
      pa[u] = ch_ack[u];
      pw[u] = we_req[u];
      pr[u] = rd_req[u];
      for (int c = 0; c < NCH; c++) begin
        issue(u, c, 1'b0, tag_addr(c, c), 16'h0);
        cnt[u][c] = 1;
      end
    end
    repeat (200) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (we_req[u] !== pw[u] || rd_req[u] !== pr[u])
          seq[u].push_back(int'(rdaddr[u][9:8]));
        pw[u] = we_req[u];
        pr[u] = rd_req[u];
        for (int c = 0; c < NCH; c++) begin
          if (ch_ack[u][c] !== pa[u][c]) begin
            if ((u == 0 && cnt[0][c] < 3) ||
                (u == 1 && c == 0 && cnt[1][0] < 4)) begin
              issue(u, c, 1'b0, tag_addr(c, c), 16'h0);
              cnt[u][c]++;
            end
          end
        end
        pa[u] = ch_ack[u];
      end
    end
    chk("rr_len", seq[0].size(), 9);
    foreach (exp_rr[i])
      if (i < seq[0].size()) chk($sformatf("rr_%0d", i), seq[0][i], exp_rr[i]);
    chk("fp_len", seq[1].size(), 6);
    foreach (exp_fp[i])
      if (i < seq[1].size()) chk($sformatf("fp_%0d", i), seq[1][i], exp_fp[i]);

    // reset while a ch2 read is in flight
    do_reset();
    lat[0] = 3;
    prev = rd_req[0];
    issue(0, 2, 1'b0, tag_addr(2, 7), 16'h0);
    k = 0;
    while (rd_req[0] === prev && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rs_grant", k < 20, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rs_ack_low", ch_ack[0], 3'b000);
    repeat (8) @(negedge clk);
    chk("rs_ack_low2", ch_ack[0], 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    prev = rd_req[0];
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (rd_req[0] !== prev) n++;
      prev = rd_req[0];
    end
    chk("rs_reissue", n, 1);
    chk("rs_ack", ch_ack[0], 3'b100);
    chk("rs_dout", ch_dout[0][47:32], ref_mem[0][7]);

    // randomized traffic against the reference model
    do_reset();
    for (int u = 0; u < 2; u++) begin
      lat[u]      = 0;
      pend[u]     = '0;
      exp_ack[u]  = '0;
      exp_dout[u] = '0;
      ptr[u]      = 0;
      cur[u]      = -1;
      acknext[u]  = -1;
      pw[u]  = we_req[u];
      pr[u]  = rd_req[u];
      pwa[u] = we_ack[u];
      pra[u] = rd_ack[u];
    end
    for (int t = 0; t < 700; t++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (acknext[u] >= 0) begin
          g = acknext[u];
          exp_ack[u][g] = ~exp_ack[u][g];
          if (q_we[u][g]) ref_mem[u][q_addr[u][g][7:0]] = q_din[u][g];
          else exp_dout[u][g*16 +: 16] = ref_mem[u][q_addr[u][g][7:0]];
          pend[u][g] = 1'b0;
          if (u == 0) ptr[u] = (g + 1) % NCH;
          acknext[u] = -1;
          cur[u] = -1;
        end
        chk("r_ack", ch_ack[u], exp_ack[u]);
        chk("r_dout", ch_dout[u], exp_dout[u]);
        wt = (we_req[u] !== pw[u]);
        rt = (rd_req[u] !== pr[u]);
        wa = (we_ack[u] !== pwa[u]);
        ra = (rd_ack[u] !== pra[u]);
        pw[u]  = we_req[u];
        pr[u]  = rd_req[u];
        pwa[u] = we_ack[u];
        pra[u] = rd_ack[u];
        if (cur[u] >= 0 && (q_we[u][cur[u]] ? wa : ra))
          acknext[u] = cur[u];
        if (wt || rt) begin
          chk("r_busy", cur[u] >= 0, 1'b0);
          g = exp_grant(u);
          chk("r_pend", g >= 0, 1'b1);
          if (g >= 0) begin
            chk("r_op", {wt, rt}, q_we[u][g] ? 2'b10 : 2'b01);
            if (q_we[u][g])
              chk("r_wr", {wraddr[u], din[u]},
                  {q_addr[u][g], 1'b0, q_din[u][g]});
            else
              chk("r_rd", rdaddr[u], q_addr[u][g]);
            cur[u] = g;
          end
        end
        if (t < 500) begin
          for (int c = 0; c < NCH; c++) begin
            if (!pend[u][c] && $urandom_range(0, 2) == 0) begin
              issue(u, c, 1'($urandom_range(0, 1)),
                    tag_addr(c, int'($urandom_range(0, 15))),
                    16'($urandom));
              pend[u][c] = 1'b1;
            end
          end
        end
      end
    end
    for (int u = 0; u < 2; u++) chk("drain", pend[u], '0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
